// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC-addressed req/ack read into an IR for decode.
// Optional req timeout with sticky fetch_err when FETCH_TIMEOUT_EN is defined.
module fetch_unit #(
    parameter int a_width = 8,
    parameter int d_width = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [a_width-1:0] pc_in,
    output logic [1:0]         pc_ctrl,
    output logic [a_width-1:0] pc_ld,
    output logic [a_width-1:0] mem_addr,
    output logic               mem_req,
    input  logic               mem_ack,
    input  logic [d_width-1:0] mem_rdata,
    output logic [d_width-1:0] ir_out,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               branch_valid,
    input  logic               branch_rel,
    input  logic [a_width-1:0] branch_target,
    output logic               fetch_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_ADD  = 2'b01;
    localparam logic [1:0] PC_INC  = 2'b10;
    localparam logic [1:0] PC_LOAD = 2'b11;

    logic [1:0]         state_q, state_d;
    logic [d_width-1:0] ir_q, ir_d;
    logic               irv_q, irv_d;
    logic               err;
    logic               tmo;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Counter sits at zero outside REQ, so every REQ entry starts fresh.
    assign tmo = (state_q == REQ) && !mem_ack
              && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if (state_q == REQ && !mem_ack && !tmo)
            cnt_d = cnt_q + 1'b1;
        if (tmo)
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT;
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        irv_d   = irv_q;
        pc_ctrl = PC_HOLD;
        pc_ld   = '0;
        unique case (state_q)
            IDLE: begin
                if (run && !err)
                    state_d = REQ;
            end
            REQ: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    irv_d   = 1'b1;
                    state_d = ISSUE;
                end else if (tmo) begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (ir_ready) begin
                    irv_d   = 1'b0;
                    state_d = run ? REQ : IDLE;
                    if (branch_valid) begin
                        pc_ctrl = branch_rel ? PC_ADD : PC_LOAD;
                        pc_ld   = branch_target;
                    end else begin
                        pc_ctrl = PC_INC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
            irv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            irv_q   <= irv_d;
        end
    end

    assign mem_addr  = pc_in;
    assign mem_req   = (state_q == REQ);
    assign ir_out    = ir_q;
    assign ir_valid  = irv_q;
    assign fetch_err = err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small PC model driven by pc_ctrl/pc_ld.
// Covers FETCH_TIMEOUT_EN when the same define is passed to the build.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  pc_in;
    logic [1:0]  pc_ctrl;
    logic [7:0]  pc_ld;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        branch_valid;
    logic        branch_rel;
    logic [7:0]  branch_target;
    logic        fetch_err;

    logic        pc_set;
    logic [7:0]  pc_set_val;
    logic [7:0]  pc;

    int total = 0;
    int passed = 0;

    fetch_unit #(.a_width(8), .d_width(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .run(run), .pc_in(pc_in),
        .pc_ctrl(pc_ctrl), .pc_ld(pc_ld), .mem_addr(mem_addr),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .branch_valid(branch_valid), .branch_rel(branch_rel),
        .branch_target(branch_target), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Program counter as seen by the fetch unit
    always @(posedge clk) begin
        if (rst) pc <= 8'h00;
        else if (pc_set) pc <= pc_set_val;
        else begin
            case (pc_ctrl)
                2'b01: pc <= pc + pc_ld;
                2'b10: pc <= pc + 8'h01;
                2'b11: pc <= pc_ld;
                default: pc <= pc;
            endcase
        end
    end
    assign pc_in = pc;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1; run = 0; mem_ack = 0; mem_rdata = 16'h0; ir_ready = 0;
        branch_valid = 0; branch_rel = 0; branch_target = 8'h0;
        pc_set = 0; pc_set_val = 8'h0;
        cyc; cyc;
        #1;
        total++;
        if (mem_req === 1'b0 && ir_valid === 1'b0 && ir_out === 16'h0 &&
            pc_ctrl === 2'b00 && pc_ld === 8'h00 && fetch_err === 1'b0)
            passed++;
        else
            $display("FAIL reset: req=%b v=%b ir=%h ctrl=%b ld=%h err=%b want all 0",
                     mem_req, ir_valid, ir_out, pc_ctrl, pc_ld, fetch_err);
        total++;
        if (mem_addr === 8'h00) passed++;
        else $display("FAIL reset_addr: got %h want 00", mem_addr);
    endtask

    task automatic test_basic;
        rst = 0; cyc;
        run = 1; #1;
        total++;
        if (mem_req === 1'b0 && pc_ctrl === 2'b00) passed++;
        else $display("FAIL idle: req=%b ctrl=%b want 0/00", mem_req, pc_ctrl);
        cyc;
        mem_ack = 1; mem_rdata = 16'h1234; ir_ready = 1; #1;
        total++;
        if (mem_req === 1'b1 && ir_valid === 1'b0 && mem_addr === 8'h00 &&
            pc_ctrl === 2'b00) passed++;
        else $display("FAIL req0: req=%b v=%b addr=%h ctrl=%b want 1/0/00/00",
                      mem_req, ir_valid, mem_addr, pc_ctrl);
        cyc;
        mem_ack = 0; #1;
        total++;
        if (ir_out === 16'h1234 && ir_valid === 1'b1 && mem_req === 1'b0 &&
            pc_ctrl === 2'b10 && pc_ld === 8'h00) passed++;
        else $display("FAIL issue0: ir=%h v=%b req=%b ctrl=%b ld=%h want 1234/1/0/10/00",
                      ir_out, ir_valid, mem_req, pc_ctrl, pc_ld);
        cyc; #1;
        total++;
        if (mem_addr === 8'h01 && mem_req === 1'b1 && ir_valid === 1'b0) passed++;
        else $display("FAIL next_req: addr=%h req=%b v=%b want 01/1/0",
                      mem_addr, mem_req, ir_valid);
    endtask

    task automatic test_wait;
        int nreq = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (mem_req === 1'b1 && pc_ctrl === 2'b00 && ir_valid === 1'b0) nreq++;
            cyc;
        end
        mem_ack = 1; mem_rdata = 16'hBEEF; ir_ready = 0; #1;
        if (mem_req === 1'b1 && pc_ctrl === 2'b00 && ir_valid === 1'b0) nreq++;
        total++;
        if (nreq == 4) passed++;
        else $display("FAIL wait_req: good req cycles %0d want 4", nreq);
        cyc;
        mem_ack = 0; #1;
        total++;
        if (ir_valid === 1'b1 && ir_out === 16'hBEEF) passed++;
        else $display("FAIL wait_cap: v=%b ir=%h want 1/beef", ir_valid, ir_out);
    endtask

    task automatic test_stall;
        int good = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (ir_out === 16'hBEEF && ir_valid === 1'b1 && mem_req === 1'b0 &&
                pc_ctrl === 2'b00) good++;
            cyc;
        end
        total++;
        if (good == 5) passed++;
        else $display("FAIL stall: good cycles %0d want 5", good);
        ir_ready = 1; #1;
        total++;
        if (pc_ctrl === 2'b10) passed++;
        else $display("FAIL stall_release: ctrl=%b want 10", pc_ctrl);
        cyc; #1;
        total++;
        if (mem_addr === 8'h02 && mem_req === 1'b1) passed++;
        else $display("FAIL stall_next: addr=%h req=%b want 02/1", mem_addr, mem_req);
    endtask

    task automatic test_branch;
        pc_set = 1; pc_set_val = 8'h05;
        branch_valid = 1; branch_rel = 1; branch_target = 8'hFE; #1;
        total++;
        if (pc_ctrl === 2'b00 && pc_ld === 8'h00) passed++;
        else $display("FAIL br_ignored: ctrl=%b ld=%h want 00/00", pc_ctrl, pc_ld);
        cyc;
        pc_set = 0; branch_valid = 0;
        mem_ack = 1; mem_rdata = 16'h00AA; #1;
        total++;
        if (mem_addr === 8'h05) passed++;
        else $display("FAIL br_setpc: addr=%h want 05", mem_addr);
        cyc;
        mem_ack = 0; branch_valid = 1; branch_rel = 1; branch_target = 8'hFE; #1;
        total++;
        if (pc_ctrl === 2'b01 && pc_ld === 8'hFE) passed++;
        else $display("FAIL br_rel: ctrl=%b ld=%h want 01/fe", pc_ctrl, pc_ld);
        cyc;
        branch_valid = 0; mem_ack = 1; mem_rdata = 16'h4040; #1;
        total++;
        if (mem_addr === 8'h03 && mem_req === 1'b1) passed++;
        else $display("FAIL br_rel_addr: addr=%h req=%b want 03/1", mem_addr, mem_req);
        cyc;
        mem_ack = 0; branch_valid = 1; branch_rel = 0; branch_target = 8'h40; #1;
        total++;
        if (pc_ctrl === 2'b11 && pc_ld === 8'h40) passed++;
        else $display("FAIL br_abs: ctrl=%b ld=%h want 11/40", pc_ctrl, pc_ld);
        cyc;
        branch_valid = 0; #1;
        total++;
        if (mem_addr === 8'h40 && mem_req === 1'b1) passed++;
        else $display("FAIL br_abs_addr: addr=%h req=%b want 40/1", mem_addr, mem_req);
    endtask

    task automatic test_run_drop;
        run = 0; mem_ack = 1; mem_rdata = 16'h7777;
        cyc;
        mem_ack = 0; #1;
        total++;
        if (ir_valid === 1'b1 && ir_out === 16'h7777 && pc_ctrl === 2'b10) passed++;
        else $display("FAIL drop_issue: v=%b ir=%h ctrl=%b want 1/7777/10",
                      ir_valid, ir_out, pc_ctrl);
        cyc; #1;
        total++;
        if (mem_req === 1'b0 && ir_valid === 1'b0 && mem_addr === 8'h41) passed++;
        else $display("FAIL drop_idle: req=%b v=%b addr=%h want 0/0/41",
                      mem_req, ir_valid, mem_addr);
        mem_ack = 1; mem_rdata = 16'h9999;
        cyc;
        mem_ack = 0; #1;
        total++;
        if (ir_out === 16'h7777 && ir_valid === 1'b0 && mem_req === 1'b0) passed++;
        else $display("FAIL idle_ack: ir=%h v=%b req=%b want 7777/0/0",
                      ir_out, ir_valid, mem_req);
    endtask

    task automatic test_reset_mid;
        run = 1; cyc;
        run = 0; #1;
        total++;
        if (mem_req === 1'b1) passed++;
        else $display("FAIL rmid_req: req=%b want 1", mem_req);
        rst = 1; mem_ack = 1; mem_rdata = 16'h5555;
        cyc;
        rst = 0; #1;
        total++;
        if (mem_req === 1'b0 && ir_valid === 1'b0 && ir_out === 16'h0 &&
            pc_ctrl === 2'b00 && pc_ld === 8'h00 && fetch_err === 1'b0 &&
            mem_addr === 8'h00) passed++;
        else $display("FAIL rmid_out: req=%b v=%b ir=%h ctrl=%b ld=%h err=%b addr=%h want reset",
                      mem_req, ir_valid, ir_out, pc_ctrl, pc_ld, fetch_err, mem_addr);
        cyc;
        mem_ack = 0; #1;
        total++;
        if (ir_valid === 1'b0 && ir_out === 16'h0 && mem_req === 1'b0) passed++;
        else $display("FAIL rmid_late: v=%b ir=%h req=%b want 0/0000/0",
                      ir_valid, ir_out, mem_req);
    endtask

    task automatic test_timeout;
        int n = 0;
        int idle_ok = 0;
        ir_ready = 0; run = 1;
        cyc;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (mem_req !== 1'b1) break;
            n++;
            cyc;
        end
`ifdef FETCH_TIMEOUT_EN
        total++;
        if (n == 15 && fetch_err === 1'b1) passed++;
        else $display("FAIL timeout: req cycles %0d err=%b want 15/1", n, fetch_err);
        for (int i = 0; i < 3; i++) begin
            cyc; #1;
            if (mem_req === 1'b0 && fetch_err === 1'b1 && ir_out === 16'h0) idle_ok++;
        end
        total++;
        if (idle_ok == 3) passed++;
        else $display("FAIL timeout_lock: good cycles %0d want 3", idle_ok);
        run = 0; rst = 1; cyc;
        rst = 0; #1;
        total++;
        if (fetch_err === 1'b0 && mem_req === 1'b0) passed++;
        else $display("FAIL timeout_clr: err=%b req=%b want 0/0", fetch_err, mem_req);
`else
        total++;
        if (n == 40 && fetch_err === 1'b0) passed++;
        else $display("FAIL no_timeout: req cycles %0d err=%b want 40/0", n, fetch_err);
        run = 0; mem_ack = 1; mem_rdata = 16'hA5A5;
        cyc;
        mem_ack = 0; ir_ready = 1; #1;
        total++;
        if (ir_out === 16'hA5A5 && ir_valid === 1'b1 && pc_ctrl === 2'b10) passed++;
        else $display("FAIL late_fetch: ir=%h v=%b ctrl=%b want a5a5/1/10",
                      ir_out, ir_valid, pc_ctrl);
        cyc; #1;
        if (mem_req === 1'b0 && ir_valid === 1'b0) idle_ok++;
        total++;
        if (idle_ok == 1) passed++;
        else $display("FAIL late_idle: req=%b v=%b want 0/0", mem_req, ir_valid);
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wait;
        test_stall;
        test_branch;
        test_run_drop;
        test_reset_mid;
        test_timeout;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
